// File: rtl/feature_map_out_scheduler.sv
// Output-feature-map writeback sequencer: buffer reads -> 144->256 converter in 16-word groups,
// one DDR write command per group. Optional stall counter under FMO_STALL_CNT_EN.
module feature_map_out_scheduler #(
  parameter int NUM_IN  = 16,
  parameter int NUM_OUT = 9,
  parameter int GRP_W   = 12,
  parameter int BUF_AW  = 16,
  parameter int ADDR_W  = 32,
  parameter int FREE_W  = 8,
  parameter int RD_LAT  = 1
) (
  input  logic              sys_clk,
  input  logic              rstn,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [GRP_W-1:0]  num_groups,
  output logic              busy,
  output logic              done,
  output logic              buf_rd_en,
  output logic [BUF_AW-1:0] buf_rd_addr,
  output logic              conv_valid_in,
  input  logic              conv_valid_out,
  input  logic [FREE_W-1:0] fifo_free,
  output logic              wr_cmd_valid,
  input  logic              wr_cmd_ready,
  output logic [ADDR_W-1:0] wr_cmd_addr,
  output logic [3:0]        wr_cmd_len,
  output logic [31:0]       stall_cycles
);

  localparam int CNT_W = GRP_W + 4;
  localparam int RC_W  = (NUM_IN > 1) ? $clog2(NUM_IN) : 1;

  typedef enum logic [2:0] {
    S_IDLE, S_SPACE, S_READ, S_CMD, S_DRAIN, S_DONE
  } state_t;

  state_t            state_q, state_d;
  logic [GRP_W-1:0]  grp_q;        // groups in this tile
  logic [GRP_W-1:0]  grp_cnt_q;    // commands accepted so far
  logic [ADDR_W-1:0] cmd_addr_q;
  logic [BUF_AW-1:0] rd_addr_q;
  logic [RC_W-1:0]   rd_cnt_q;
  logic [CNT_W-1:0]  beats_q;      // beats seen from the converter
  logic [CNT_W-1:0]  exp_beats_q;  // groups_issued * NUM_OUT, kept as a running sum
  logic [RD_LAT-1:0] vld_dly_q;

  logic start_acc, cmd_fire, no_inflight, space_ok, last_rd, last_grp;

  assign start_acc   = (state_q == S_IDLE) && start;
  assign cmd_fire    = (state_q == S_CMD) && wr_cmd_ready;
  assign no_inflight = (beats_q == exp_beats_q);
  assign space_ok    = (fifo_free >= FREE_W'(NUM_OUT)) && no_inflight;
  assign last_rd     = (rd_cnt_q == RC_W'(NUM_IN - 1));
  assign last_grp    = (grp_cnt_q == grp_q - 1'b1);

  // NOTE: next-state logic assigns its default first so no path leaves state_d unassigned (no latch).
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (start) state_d = S_SPACE;
      S_SPACE: begin
        if (grp_q == '0)   state_d = S_DONE;
        else if (space_ok) state_d = S_READ;
      end
      S_READ:  if (last_rd) state_d = S_CMD;
      S_CMD:   if (wr_cmd_ready) state_d = last_grp ? S_DRAIN : S_SPACE;
      S_DRAIN: if (no_inflight) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: all sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge sys_clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= S_IDLE;
      grp_q       <= '0;
      grp_cnt_q   <= '0;
      cmd_addr_q  <= '0;
      rd_addr_q   <= '0;
      rd_cnt_q    <= '0;
      beats_q     <= '0;
      exp_beats_q <= '0;
    end else begin
      state_q <= state_d;
      if (start_acc) begin
        grp_q       <= num_groups;
        cmd_addr_q  <= base_addr;
        grp_cnt_q   <= '0;
        rd_addr_q   <= '0;
        rd_cnt_q    <= '0;
        beats_q     <= '0;
        exp_beats_q <= '0;
      end else begin
        if (state_q == S_READ) begin
          rd_addr_q <= rd_addr_q + 1'b1;
          rd_cnt_q  <= last_rd ? '0 : rd_cnt_q + 1'b1;
        end
        if (cmd_fire) begin
          cmd_addr_q  <= cmd_addr_q + ADDR_W'(NUM_OUT);
          grp_cnt_q   <= grp_cnt_q + 1'b1;
          exp_beats_q <= exp_beats_q + CNT_W'(NUM_OUT);
        end
        if (busy && conv_valid_out) beats_q <= beats_q + 1'b1;
      end
    end
  end

  // NOTE: the read-valid delay line is reset so a stale valid cannot reach the converter after rstn.
  always_ff @(posedge sys_clk or negedge rstn) begin
    if (!rstn) vld_dly_q <= '0;
    else       vld_dly_q <= (vld_dly_q << 1) | RD_LAT'(buf_rd_en);
  end

  assign busy          = (state_q == S_SPACE) || (state_q == S_READ) ||
                         (state_q == S_CMD)   || (state_q == S_DRAIN);
  assign done          = (state_q == S_DONE);
  assign buf_rd_en     = (state_q == S_READ);
  assign buf_rd_addr   = rd_addr_q;
  assign conv_valid_in = vld_dly_q[RD_LAT-1];
  assign wr_cmd_valid  = (state_q == S_CMD);
  // Command fields are qualified by valid so the channel idles at zero.
  assign wr_cmd_addr   = wr_cmd_valid ? cmd_addr_q : '0;
  assign wr_cmd_len    = wr_cmd_valid ? 4'(NUM_OUT) : 4'd0;

`ifdef FMO_STALL_CNT_EN
  logic [31:0] stall_q;
  logic        stall_now;

  assign stall_now = busy && (((state_q == S_SPACE) && (grp_q != '0) && !space_ok) ||
                              ((state_q == S_CMD) && !wr_cmd_ready));

  always_ff @(posedge sys_clk or negedge rstn) begin
    if (!rstn)                         stall_q <= '0;
    else if (start_acc)                stall_q <= '0;
    else if (stall_now && ~&stall_q)   stall_q <= stall_q + 1'b1;
  end

  assign stall_cycles = stall_q;
`else
  assign stall_cycles = '0;
`endif

endmodule

// File: tb/tb_feature_map_out_scheduler.sv
// Scoreboard bench for feature_map_out_scheduler with a 144->256 converter model in the loop.
module tb_feature_map_out_scheduler;

  logic        sys_clk = 1'b0;
  logic        rstn;
  logic        start;
  logic [31:0] base_addr;
  logic [11:0] num_groups;
  logic        busy, done, buf_rd_en, conv_valid_in, conv_valid_out, wr_cmd_valid, wr_cmd_ready;
  logic [15:0] buf_rd_addr;
  logic [7:0]  fifo_free;
  logic [31:0] wr_cmd_addr, stall_cycles;
  logic [3:0]  wr_cmd_len;

  feature_map_out_scheduler dut (
    .sys_clk(sys_clk), .rstn(rstn), .start(start), .base_addr(base_addr),
    .num_groups(num_groups), .busy(busy), .done(done), .buf_rd_en(buf_rd_en),
    .buf_rd_addr(buf_rd_addr), .conv_valid_in(conv_valid_in), .conv_valid_out(conv_valid_out),
    .fifo_free(fifo_free), .wr_cmd_valid(wr_cmd_valid), .wr_cmd_ready(wr_cmd_ready),
    .wr_cmd_addr(wr_cmd_addr), .wr_cmd_len(wr_cmd_len), .stall_cycles(stall_cycles)
  );

  always #5 sys_clk = ~sys_clk;

  // Converter model: 144 bits in per valid, one 256-bit beat out whenever a full beat is buffered.
  int acc;
  always @(posedge sys_clk or negedge rstn) begin
    if (!rstn) begin
      acc <= 0;
      conv_valid_out <= 1'b0;
    end else begin
      conv_valid_out <= 1'b0;
      if (conv_valid_in) begin
        if (acc + 144 >= 256) begin
          acc <= acc + 144 - 256;
          conv_valid_out <= 1'b1;
        end else begin
          acc <= acc + 144;
        end
      end
    end
  end

  int tests_run = 0, tests_failed = 0;
  logic [15:0] exp_rd_q[$];
  logic [31:0] exp_cmd_q[$];
  int beat_cnt, done_cnt, rd_cnt, cmd_valid_cycles;

  // Monitor samples 1 time unit after the falling edge, after the tasks have driven inputs.
  always @(negedge sys_clk) begin
    #1;
    if (rstn) begin
      if (conv_valid_out) beat_cnt++;
      if (done) done_cnt++;
      if (wr_cmd_valid) cmd_valid_cycles++;
      if (buf_rd_en) begin
        rd_cnt++;
        tests_run++;
        if (exp_rd_q.size() == 0) begin
          tests_failed++;
          $display("FAIL rd_extra: got read addr %0d, expected no read", buf_rd_addr);
        end else begin
          logic [15:0] e;
          e = exp_rd_q.pop_front();
          if (buf_rd_addr !== e) begin
            tests_failed++;
            $display("FAIL rd_addr: got %0d expected %0d", buf_rd_addr, e);
          end
        end
      end
      if (wr_cmd_valid && wr_cmd_ready) begin
        tests_run++;
        if (exp_cmd_q.size() == 0) begin
          tests_failed++;
          $display("FAIL cmd_extra: got cmd addr %0h, expected no command", wr_cmd_addr);
        end else begin
          logic [31:0] e;
          e = exp_cmd_q.pop_front();
          if (wr_cmd_addr !== e || wr_cmd_len !== 4'd9) begin
            tests_failed++;
            $display("FAIL cmd: got addr %0h len %0d expected addr %0h len 9",
                     wr_cmd_addr, wr_cmd_len, e);
          end
        end
      end
    end
  end

  task automatic new_tile(input logic [31:0] ba, input int ng);
    beat_cnt = 0; done_cnt = 0; rd_cnt = 0; cmd_valid_cycles = 0;
    exp_rd_q.delete(); exp_cmd_q.delete();
    for (int g = 0; g < ng; g++) exp_cmd_q.push_back(ba + 32'(g * 9));
    for (int i = 0; i < ng * 16; i++) exp_rd_q.push_back(16'(i));
  endtask

  task automatic pulse_start(input logic [31:0] ba, input logic [11:0] ng);
    @(negedge sys_clk);
    base_addr = ba; num_groups = ng; start = 1'b1;
    @(negedge sys_clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input string name, input int budget);
    int n = 0;
    while (!done && n < budget) begin
      @(negedge sys_clk);
      n++;
    end
    tests_run++;
    if (done !== 1'b1) begin
      tests_failed++;
      $display("FAIL %s_timeout: no done within %0d cycles", name, budget);
    end
    repeat (3) @(negedge sys_clk);
  endtask

  task automatic wait_rd(input string name, input int budget);
    int n = 0;
    while (!buf_rd_en && n < budget) begin
      @(negedge sys_clk);
      n++;
    end
    tests_run++;
    if (buf_rd_en !== 1'b1) begin
      tests_failed++;
      $display("FAIL %s_rd_timeout: no buf_rd_en within %0d cycles", name, budget);
    end
  endtask

  task automatic check_tile(input string name, input int ng);
    tests_run++;
    if (done_cnt !== 1) begin
      tests_failed++;
      $display("FAIL %s_done_cnt: got %0d expected 1", name, done_cnt);
    end
    tests_run++;
    if (beat_cnt !== ng * 9) begin
      tests_failed++;
      $display("FAIL %s_beats: got %0d expected %0d", name, beat_cnt, ng * 9);
    end
    tests_run++;
    if (rd_cnt !== ng * 16 || exp_rd_q.size() != 0 || exp_cmd_q.size() != 0) begin
      tests_failed++;
      $display("FAIL %s_complete: got %0d reads, %0d reads and %0d cmds pending; expected %0d reads, 0 pending",
               name, rd_cnt, exp_rd_q.size(), exp_cmd_q.size(), ng * 16);
    end
    tests_run++;
    if (busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL %s_idle: got busy %b expected 0", name, busy);
    end
  endtask

  task automatic check_all_zero(input string name);
    logic [111:0] outs;
    outs = {busy, done, buf_rd_en, buf_rd_addr, conv_valid_in, wr_cmd_valid,
            wr_cmd_addr, wr_cmd_len, stall_cycles};
    tests_run++;
    if (outs !== '0) begin
      tests_failed++;
      $display("FAIL %s: got outputs %0h expected all 0", name, outs);
    end
  endtask

  task automatic test_reset();
    #1 check_all_zero("reset_por");
    @(negedge sys_clk) rstn = 1'b1;
    new_tile(32'h40, 2);
    pulse_start(32'h40, 12'd2);
    wait_rd("reset", 50);
    repeat (4) @(negedge sys_clk);
    #2 rstn = 1'b0;
    #1 check_all_zero("reset_mid_read");
    exp_rd_q.delete(); exp_cmd_q.delete();
    @(negedge sys_clk) rstn = 1'b1;
    repeat (4) @(negedge sys_clk);
    tests_run++;
    if (busy !== 1'b0 || buf_rd_addr !== 16'd0 || done_cnt !== 0) begin
      tests_failed++;
      $display("FAIL reset_release: got busy %b addr %0d dones %0d expected 0 0 0",
               busy, buf_rd_addr, done_cnt);
    end
  endtask

  task automatic test_basic();
    new_tile(32'h100, 2);
    pulse_start(32'h100, 12'd2);
    tests_run++;
    if (busy !== 1'b1) begin
      tests_failed++;
      $display("FAIL basic_busy: got %b expected 1", busy);
    end
    wait_done("basic", 400);
    check_tile("basic", 2);
  endtask

  task automatic test_zero_groups();
    new_tile(32'h700, 0);
    pulse_start(32'h700, 12'd0);
    tests_run++;
    if (busy !== 1'b1 || done !== 1'b0) begin
      tests_failed++;
      $display("FAIL zero_cycle1: got busy %b done %b expected 1 0", busy, done);
    end
    @(negedge sys_clk);
    tests_run++;
    if (done !== 1'b1 || busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL zero_cycle2: got done %b busy %b expected 1 0", done, busy);
    end
    repeat (4) @(negedge sys_clk);
    tests_run++;
    if (done_cnt !== 1 || rd_cnt !== 0 || cmd_valid_cycles !== 0) begin
      tests_failed++;
      $display("FAIL zero_activity: got dones %0d reads %0d cmd cycles %0d expected 1 0 0",
               done_cnt, rd_cnt, cmd_valid_cycles);
    end
  endtask

  task automatic test_backpressure();
    bit seen_rd = 1'b0;
    fifo_free = 8'd8;
    new_tile(32'h300, 1);
    pulse_start(32'h300, 12'd1);
    for (int i = 0; i < 20; i++) begin
      @(negedge sys_clk);
      if (buf_rd_en) seen_rd = 1'b1;
    end
    tests_run++;
    if (seen_rd) begin
      tests_failed++;
      $display("FAIL bp_no_read: got buf_rd_en while fifo_free=8, expected none");
    end
    fifo_free = 8'd9;
    wait_rd("bp", 10);
    wait_done("bp", 200);
    check_tile("bp", 1);
    tests_run++;
`ifdef FMO_STALL_CNT_EN
    if (stall_cycles < 32'd20) begin
      tests_failed++;
      $display("FAIL bp_stall: got %0d expected >= 20", stall_cycles);
    end
`else
    if (stall_cycles !== 32'd0) begin
      tests_failed++;
      $display("FAIL bp_stall: got %0d expected 0", stall_cycles);
    end
`endif
    fifo_free = 8'd32;
  endtask

  task automatic test_cmd_stall();
    int n = 0;
    wr_cmd_ready = 1'b0;
    new_tile(32'h500, 2);
    pulse_start(32'h500, 12'd2);
    while (!wr_cmd_valid && n < 100) begin
      @(negedge sys_clk);
      n++;
    end
    for (int k = 0; k < 6; k++) begin
      tests_run++;
      if (wr_cmd_valid !== 1'b1 || wr_cmd_addr !== 32'h500 || wr_cmd_len !== 4'd9 ||
          buf_rd_en !== 1'b0) begin
        tests_failed++;
        $display("FAIL cmd_stall_hold%0d: got valid %b addr %0h len %0d rd %b expected 1 500 9 0",
                 k, wr_cmd_valid, wr_cmd_addr, wr_cmd_len, buf_rd_en);
      end
      if (k == 5) wr_cmd_ready = 1'b1;
      @(negedge sys_clk);
    end
    tests_run++;
    if (wr_cmd_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL cmd_stall_drop: got valid %b expected 0", wr_cmd_valid);
    end
    wait_done("cmd_stall", 400);
    check_tile("cmd_stall", 2);
  endtask

  task automatic test_start_while_busy();
    new_tile(32'h2000, 2);
    pulse_start(32'h2000, 12'd2);
    wait_rd("restart", 50);
    repeat (3) @(negedge sys_clk);
    pulse_start(32'hDEAD0, 12'd5);
    wait_done("restart", 400);
    check_tile("restart", 2);
    repeat (10) @(negedge sys_clk);
    tests_run++;
    if (busy !== 1'b0 || done_cnt !== 1) begin
      tests_failed++;
      $display("FAIL restart_quiet: got busy %b dones %0d expected 0 1", busy, done_cnt);
    end
  endtask

  initial begin
    rstn = 1'b0; start = 1'b0; base_addr = '0; num_groups = '0;
    fifo_free = 8'd32; wr_cmd_ready = 1'b1;
    beat_cnt = 0; done_cnt = 0; rd_cnt = 0; cmd_valid_cycles = 0;
    test_reset();
    test_basic();
    test_zero_groups();
    test_backpressure();
    test_cmd_stall();
    test_start_while_busy();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
